// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad lock controller. Collects 6-digit codes from debounced
// key events, checks them against the user code or the program code, drives the
// blinker handshake, times the unlock window and the failed-attempt lockout, and
// runs the program-code authorised change-code / confirm sequence.
module lock_sequencer #(
  parameter logic [23:0] UC_INIT        = 24'h123456,
  parameter logic [23:0] PC_CODE        = 24'h666666,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [31:0] UNLOCK_CYCLES  = 32'd36000000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd120000000
) (
  input  logic        hwclk,
  input  logic        rst,
  input  logic [3:0]  button,
  input  logic        bstate,
  input  logic        done_blink,
  output logic        start_blink,
  output logic        blink_type,
  output logic        unlocked,
  output logic        locked_out,
  output logic [1:0]  mode,
  output logic [2:0]  digit_count,
  output logic [23:0] uc_code
);

  typedef enum logic [2:0] {
    S_ENTER_UC,
    S_ENTER_PC,
    S_ENTER_NEW,
    S_CONFIRM,
    S_BLINK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAILS);

  state_t      state, state_next;
  state_t      after_blink, after_blink_next;
  state_t      blink_dest;
  logic        bstate_d;
  logic [3:0]  key;
  logic [19:0] code_buf, code_buf_next;
  logic [2:0]  digit_count_next;
  logic [2:0]  fails, fails_next;
  logic [23:0] uc_code_next;
  logic [23:0] new_code, new_code_next;
  logic [31:0] timer, timer_next;
  logic        start_blink_next, blink_type_next;
  logic        blink_now, blink_ok, attempt_failed;

  logic        key_event;
  logic [23:0] full_code;
  logic [3:0]  fails_inc;

  // A key event is the release edge of bstate; the code under test always
  // includes the key being released, so a 6th digit compares before buffering.
  assign key_event = bstate_d & ~bstate;
  assign full_code = {code_buf, key};
  assign fails_inc = {1'b0, fails} + 4'd1;

  // Remember the previous key-held flag and capture the key while it is held
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      bstate_d <= 1'b0;
      key      <= 4'd0;
    end else begin
      bstate_d <= bstate;
      if (bstate) key <= button;
    end
  end

  // Next-state and datapath decisions for the single controlling FSM
  always_comb begin
    state_next       = state;
    after_blink_next = after_blink;
    code_buf_next    = code_buf;
    digit_count_next = digit_count;
    fails_next       = fails;
    uc_code_next     = uc_code;
    new_code_next    = new_code;
    timer_next       = timer;
    start_blink_next = 1'b0;
    blink_type_next  = blink_type;
    blink_now        = 1'b0;
    blink_ok         = 1'b0;
    blink_dest       = S_ENTER_UC;
    attempt_failed   = 1'b0;

    unique case (state)
      S_ENTER_UC, S_ENTER_PC, S_ENTER_NEW, S_CONFIRM: begin
        if (key_event) begin
          if (key == 4'd9) begin
            code_buf_next    = '0;
            digit_count_next = '0;
            state_next       = S_ENTER_UC;
          end else if (key == 4'd8) begin
            if (state == S_ENTER_UC && digit_count == 3'd0) state_next = S_ENTER_PC;
          end else if (key >= 4'd1 && key <= 4'd7) begin
            if (digit_count == 3'd5) begin
              code_buf_next    = '0;
              digit_count_next = '0;
              if (state == S_ENTER_UC) begin
                if (full_code == uc_code) begin
                  fails_next = '0;
                  blink_now  = 1'b1;
                  blink_ok   = 1'b1;
                  blink_dest = S_UNLOCKED;
                end else begin
                  attempt_failed = 1'b1;
                end
              end else if (state == S_ENTER_PC) begin
                if (full_code == PC_CODE) begin
                  fails_next = '0;
                  blink_now  = 1'b1;
                  blink_ok   = 1'b1;
                  blink_dest = S_ENTER_NEW;
                end else begin
                  attempt_failed = 1'b1;
                end
              end else if (state == S_ENTER_NEW) begin
                new_code_next = full_code;
                state_next    = S_CONFIRM;
              end else begin
                blink_now  = 1'b1;
                blink_dest = S_ENTER_UC;
                if (full_code == new_code) begin
                  uc_code_next = new_code;
                  blink_ok     = 1'b1;
                end
              end
            end else begin
              code_buf_next    = full_code[19:0];
              digit_count_next = digit_count + 3'd1;
            end
          end
        end
      end
      S_BLINK: begin
        // A done pulse in the same cycle as start belongs to a previous pattern
        if (done_blink && !start_blink) begin
          state_next = after_blink;
          if (after_blink == S_UNLOCKED) timer_next = UNLOCK_CYCLES - 32'd1;
          else if (after_blink == S_LOCKOUT) timer_next = LOCKOUT_CYCLES - 32'd1;
        end
      end
      S_UNLOCKED: begin
        if (timer == 32'd0) state_next = S_ENTER_UC;
        else timer_next = timer - 32'd1;
      end
      S_LOCKOUT: begin
        if (timer == 32'd0) begin
          state_next = S_ENTER_UC;
          fails_next = '0;
        end else begin
          timer_next = timer - 32'd1;
        end
      end
      default: state_next = S_ENTER_UC;
    endcase

    if (attempt_failed) begin
      fails_next = fails_inc[2:0];
      blink_now  = 1'b1;
      blink_ok   = 1'b0;
      blink_dest = (fails_inc == FAIL_LIMIT) ? S_LOCKOUT : S_ENTER_UC;
    end

    if (blink_now) begin
      start_blink_next = 1'b1;
      blink_type_next  = blink_ok;
      after_blink_next = blink_dest;
      state_next       = S_BLINK;
    end
  end

  // State and datapath registers; reset restores the factory user code
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state       <= S_ENTER_UC;
      after_blink <= S_ENTER_UC;
      code_buf    <= '0;
      digit_count <= '0;
      fails       <= '0;
      uc_code     <= UC_INIT;
      new_code    <= '0;
      timer       <= '0;
      start_blink <= 1'b0;
      blink_type  <= 1'b0;
    end else begin
      state       <= state_next;
      after_blink <= after_blink_next;
      code_buf    <= code_buf_next;
      digit_count <= digit_count_next;
      fails       <= fails_next;
      uc_code     <= uc_code_next;
      new_code    <= new_code_next;
      timer       <= timer_next;
      start_blink <= start_blink_next;
      blink_type  <= blink_type_next;
    end
  end

  // Mode tells the keypad UI which code is being typed; idle states read as user entry
  always_comb begin
    mode = 2'b00;
    case (state)
      S_ENTER_PC:  mode = 2'b01;
      S_ENTER_NEW: mode = 2'b10;
      S_CONFIRM:   mode = 2'b11;
      default:     mode = 2'b00;
    endcase
  end

  assign unlocked   = (state == S_UNLOCKED);
  assign locked_out = (state == S_LOCKOUT);

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed scenarios plus randomized key traffic, checked every
// cycle against a behavioural model of the lock rules kept in this bench.
module tb_lock_sequencer;

  localparam int          N_UNLOCK = 20;
  localparam int          N_LOCK   = 30;
  localparam int          N_FAILS  = 3;
  localparam logic [23:0] UC_RESET = 24'h123456;
  localparam logic [23:0] PC_FIXED = 24'h666666;

  // Model phases, numbered so that entry phases equal their mode value
  localparam int P_UC = 0, P_PC = 1, P_NEW = 2, P_CONF = 3, P_BLINK = 4, P_OPEN = 5, P_LOCK = 6;

  logic        hwclk = 1'b0;
  logic        rst;
  logic [3:0]  button;
  logic        bstate;
  logic        done_blink;
  logic        start_blink, blink_type, unlocked, locked_out;
  logic [1:0]  mode;
  logic [2:0]  digit_count;
  logic [23:0] uc_code;

  int total = 0;
  int bad   = 0;

  int blink_delay = 2;
  bit coincide    = 1'b0;
  int hold_cycles = 2;

  int   cnt_start = 0, cnt_open = 0, cnt_lock = 0;
  logic last_type = 1'b0;

  int          m_phase, m_after, m_fails, m_deadline, cyc;
  bit          m_bd;
  logic [3:0]  m_key;
  int          m_digits[$];
  logic [23:0] m_user, m_new;
  logic        e_start, e_type;

  lock_sequencer #(
    .UC_INIT(UC_RESET), .PC_CODE(PC_FIXED), .MAX_FAILS(N_FAILS),
    .UNLOCK_CYCLES(32'(N_UNLOCK)), .LOCKOUT_CYCLES(32'(N_LOCK))
  ) dut (
    .hwclk(hwclk), .rst(rst), .button(button), .bstate(bstate), .done_blink(done_blink),
    .start_blink(start_blink), .blink_type(blink_type), .unlocked(unlocked),
    .locked_out(locked_out), .mode(mode), .digit_count(digit_count), .uc_code(uc_code)
  );

  always #5 hwclk = ~hwclk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_UC; m_after = P_UC; m_fails = 0; m_deadline = 0; cyc = 0;
    m_bd = 1'b0; m_key = 4'd0; m_digits.delete();
    m_user = UC_RESET; m_new = '0; e_start = 1'b0; e_type = 1'b0;
  endtask

  task automatic model_blink(input logic ok, input int dest);
    e_start = 1'b1; e_type = ok; m_after = dest; m_phase = P_BLINK;
  endtask

  task automatic model_reject();
    m_fails++;
    model_blink(1'b0, (m_fails == N_FAILS) ? P_LOCK : P_UC);
  endtask

  task automatic model_key(input logic [3:0] kv);
    int code;
    logic [23:0] c;
    if (kv == 4'd9) begin
      m_digits.delete(); m_phase = P_UC;
    end else if (kv == 4'd8) begin
      if (m_phase == P_UC && m_digits.size() == 0) m_phase = P_PC;
    end else if (kv >= 4'd1 && kv <= 4'd7) begin
      m_digits.push_back(int'(kv));
      if (m_digits.size() == 6) begin
        code = 0;
        foreach (m_digits[i]) code = code * 16 + m_digits[i];
        c = code[23:0];
        m_digits.delete();
        case (m_phase)
          P_UC: if (c == m_user) begin m_fails = 0; model_blink(1'b1, P_OPEN); end else model_reject();
          P_PC: if (c == PC_FIXED) begin m_fails = 0; model_blink(1'b1, P_NEW); end else model_reject();
          P_NEW: begin m_new = c; m_phase = P_CONF; end
          default: begin
            if (c == m_new) begin m_user = m_new; model_blink(1'b1, P_UC); end
            else model_blink(1'b0, P_UC);
          end
        endcase
      end
    end
  endtask

  task automatic model_step();
    bit ev;
    logic [3:0] kv;
    logic was_start;
    ev = m_bd && !bstate;
    kv = m_key;
    if (bstate) m_key = button;
    m_bd = bstate;
    was_start = e_start;
    e_start = 1'b0;
    cyc++;
    if (m_phase <= P_CONF) begin
      if (ev) model_key(kv);
    end else if (m_phase == P_BLINK) begin
      if (done_blink && !was_start) begin
        m_phase = m_after;
        if (m_after == P_OPEN) m_deadline = cyc + N_UNLOCK;
        if (m_after == P_LOCK) m_deadline = cyc + N_LOCK;
      end
    end else if (m_phase == P_OPEN) begin
      if (cyc == m_deadline) m_phase = P_UC;
    end else begin
      if (cyc == m_deadline) begin m_phase = P_UC; m_fails = 0; end
    end
  endtask

  // Reference model advances on every active edge, or resets immediately
  initial begin
    model_reset();
    forever begin
      @(posedge hwclk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every DUT output against the model on each falling edge
  initial begin
    forever begin
      @(negedge hwclk);
      if (!rst) begin
        checkOutput("start_blink", 32'(start_blink), 32'(e_start));
        checkOutput("blink_type", 32'(blink_type), 32'(e_type));
        checkOutput("unlocked", 32'(unlocked), 32'(m_phase == P_OPEN));
        checkOutput("locked_out", 32'(locked_out), 32'(m_phase == P_LOCK));
        checkOutput("mode", 32'(mode), 32'((m_phase <= P_CONF) ? m_phase : 0));
        checkOutput("digit_count", 32'(digit_count), 32'(m_digits.size()));
        checkOutput("uc_code", 32'(uc_code), 32'(m_user));
      end
    end
  end

  // Event counters used by the directed scenarios
  initial begin
    forever begin
      @(negedge hwclk);
      if (!rst) begin
        if (start_blink === 1'b1) begin cnt_start++; last_type = blink_type; end
        if (unlocked === 1'b1) cnt_open++;
        if (locked_out === 1'b1) cnt_lock++;
      end
    end
  end

  // Blinker stand-in: answers each start with a done pulse blink_delay cycles later
  initial begin
    done_blink = 1'b0;
    forever begin
      @(negedge hwclk);
      if (!rst && start_blink === 1'b1) begin
        done_blink = coincide;
        for (int i = 0; i < blink_delay; i++) begin
          @(negedge hwclk);
          done_blink = 1'b0;
        end
        done_blink = 1'b1;
        @(negedge hwclk);
        done_blink = 1'b0;
      end
    end
  end

  task automatic snap(output int s, output int o, output int l);
    #1;
    s = cnt_start; o = cnt_open; l = cnt_lock;
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    @(negedge hwclk);
    bstate = 1'b1; button = k;
    repeat (hold_cycles) @(negedge hwclk);
    bstate = 1'b0; button = 4'($urandom);
  endtask

  task automatic enter6(input logic [23:0] code);
    for (int i = 5; i >= 0; i--) applyStimulus(code[i*4 +: 4]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge hwclk);
    while (m_phase > P_CONF && n < 300) begin
      @(negedge hwclk);
      n++;
    end
    if (m_phase > P_CONF) begin
      total++; bad++;
      $display("[TB] FAIL wait_idle %s: still busy after %0d cycles, want entry state", tag, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge hwclk);
    #2 rst = 1'b1; bstate = 1'b0; button = 4'd0;
    @(negedge hwclk);
    @(negedge hwclk);
    rst = 1'b0;
  endtask

  function automatic logic [23:0] rand_code();
    logic [23:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = {c[19:0], 4'($urandom_range(1, 7))};
    return c;
  endfunction

  int s0, o0, l0, s1, o1, l1;
  int sel;
  logic [23:0] nc;

  initial begin
    rst = 1'b1; bstate = 1'b0; button = 4'd0;
    repeat (3) @(negedge hwclk);
    rst = 1'b0;
    @(negedge hwclk);
    checkOutput("reset start_blink", 32'(start_blink), 32'd0);
    checkOutput("reset unlocked", 32'(unlocked), 32'd0);
    checkOutput("reset locked_out", 32'(locked_out), 32'd0);
    checkOutput("reset mode", 32'(mode), 32'd0);
    checkOutput("reset digit_count", 32'(digit_count), 32'd0);
    checkOutput("reset uc_code", 32'(uc_code), 32'h123456);

    $display("[TB] unlock with the factory code");
    snap(s0, o0, l0);
    enter6(24'h123456);
    wait_idle("unlock");
    snap(s1, o1, l1);
    checkOutput("unlock starts", 32'(s1 - s0), 32'd1);
    checkOutput("unlock type", 32'(last_type), 32'd1);
    checkOutput("unlock length", 32'(o1 - o0), 32'(N_UNLOCK));

    $display("[TB] three failures lead to lockout");
    enter6(24'h111111); wait_idle("fail1");
    checkOutput("fail1 type", 32'(last_type), 32'd0);
    enter6(24'h111111); wait_idle("fail2");
    snap(s0, o0, l0);
    checkOutput("no lockout before limit", 32'(l0), 32'd0);
    enter6(24'h111111);
    repeat (6) @(negedge hwclk);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    @(negedge hwclk);
    checkOutput("lockout digit_count", 32'(digit_count), 32'd0);
    checkOutput("lockout flag", 32'(locked_out), 32'd1);
    wait_idle("lockout");
    snap(s1, o1, l1);
    checkOutput("lockout length", 32'(l1 - l0), 32'(N_LOCK));
    checkOutput("fail3 type", 32'(last_type), 32'd0);
    enter6(24'h123456); wait_idle("after lockout");
    snap(s0, o0, l0);
    checkOutput("unlock after lockout", 32'(o0 - o1), 32'(N_UNLOCK));

    $display("[TB] change code to 777777");
    applyStimulus(4'd8);
    @(negedge hwclk);
    checkOutput("mode pc", 32'(mode), 32'd1);
    enter6(24'h666666); wait_idle("pc");
    checkOutput("pc type", 32'(last_type), 32'd1);
    checkOutput("mode new", 32'(mode), 32'd2);
    enter6(24'h777777);
    @(negedge hwclk);
    checkOutput("mode confirm", 32'(mode), 32'd3);
    checkOutput("uc before confirm", 32'(uc_code), 32'h123456);
    enter6(24'h777777); wait_idle("confirm");
    checkOutput("confirm type", 32'(last_type), 32'd1);
    checkOutput("uc changed", 32'(uc_code), 32'h777777);
    enter6(24'h123456); wait_idle("old code");
    checkOutput("old code rejected", 32'(last_type), 32'd0);
    snap(s0, o0, l0);
    enter6(24'h777777); wait_idle("new code");
    snap(s1, o1, l1);
    checkOutput("new code unlocks", 32'(o1 - o0), 32'(N_UNLOCK));

    $display("[TB] confirm mismatch keeps the old code");
    apply_reset();
    applyStimulus(4'd8);
    enter6(24'h666666); wait_idle("pc2");
    enter6(24'h777777);
    enter6(24'h777771); wait_idle("bad confirm");
    checkOutput("bad confirm type", 32'(last_type), 32'd0);
    checkOutput("uc kept", 32'(uc_code), 32'h123456);
    snap(s0, o0, l0);
    enter6(24'h111111); wait_idle("f1");
    enter6(24'h111111); wait_idle("f2");
    snap(s1, o1, l1);
    checkOutput("fails not bumped", 32'(l1 - l0), 32'd0);
    enter6(24'h111111); wait_idle("f3");
    snap(s0, o0, l0);
    checkOutput("third fail locks", 32'(l0 - l1), 32'(N_LOCK));

    $display("[TB] clear and change-request gating");
    applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd3);
    @(negedge hwclk);
    checkOutput("count three", 32'(digit_count), 32'd3);
    applyStimulus(4'd9);
    @(negedge hwclk);
    checkOutput("count cleared", 32'(digit_count), 32'd0);
    applyStimulus(4'd8);
    @(negedge hwclk);
    checkOutput("key8 after clear", 32'(mode), 32'd1);
    applyStimulus(4'd9); applyStimulus(4'd1); applyStimulus(4'd2); applyStimulus(4'd8);
    @(negedge hwclk);
    checkOutput("key8 mid entry mode", 32'(mode), 32'd0);
    checkOutput("key8 mid entry count", 32'(digit_count), 32'd2);
    applyStimulus(4'd9);

    $display("[TB] reset during confirm");
    applyStimulus(4'd8);
    enter6(24'h666666); wait_idle("pc3");
    enter6(24'h777777);
    enter6(24'h777777); wait_idle("confirm3");
    applyStimulus(4'd8);
    enter6(24'h666666); wait_idle("pc4");
    enter6(24'h444444);
    @(negedge hwclk);
    checkOutput("confirm before reset", 32'(mode), 32'd3);
    checkOutput("uc before reset", 32'(uc_code), 32'h777777);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst start_blink", 32'(start_blink), 32'd0);
    checkOutput("rst blink_type", 32'(blink_type), 32'd0);
    checkOutput("rst unlocked", 32'(unlocked), 32'd0);
    checkOutput("rst locked_out", 32'(locked_out), 32'd0);
    checkOutput("rst mode", 32'(mode), 32'd0);
    checkOutput("rst digit_count", 32'(digit_count), 32'd0);
    checkOutput("rst uc_code", 32'(uc_code), 32'h123456);
    @(negedge hwclk);
    @(negedge hwclk);
    rst = 1'b0;

    $display("[TB] randomized key traffic");
    for (int it = 0; it < 120; it++) begin
      blink_delay = $urandom_range(1, 4);
      coincide    = ($urandom_range(0, 3) == 0);
      hold_cycles = $urandom_range(1, 3);
      sel         = $urandom_range(0, 9);
      if (sel < 4) begin
        applyStimulus(4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 2)) @(negedge hwclk);
      end else if (sel < 7) begin
        wait_idle("rand pre");
        applyStimulus(4'd9);
        enter6(($urandom_range(0, 3) == 0) ? rand_code() : m_user);
        wait_idle("rand code");
      end else begin
        wait_idle("rand pre2");
        applyStimulus(4'd9);
        applyStimulus(4'd8);
        enter6(($urandom_range(0, 4) == 0) ? rand_code() : PC_FIXED);
        wait_idle("rand pc");
        nc = rand_code();
        enter6(nc);
        enter6(($urandom_range(0, 2) == 0) ? rand_code() : nc);
        wait_idle("rand confirm");
      end
    end
    repeat (5) @(negedge hwclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
